// File: rtl/cv32e40s_xif_result_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40s_xif_result_buffer_if
// Description : Bundles the commit, functional-unit and core-result signals
//               of the coprocessor result buffer.
//               slave  : the result buffer itself
//               master : the environment driving commits / FU results and
//                        accepting core results
// Ports       : commit_valid_i / commit_id_i / commit_kill_i : commit channel
//               fu_valid_i / fu_ready_o / fu_result_i         : FU result in
//               result_valid_o / result_ready_i / result_o    : core result out
//               count_o                                       : FIFO occupancy
// Revision    : 1.0 - initial release
// ============================================================================
interface cv32e40s_xif_result_buffer_if #(
   parameter int X_ID_WIDTH  = 4,
   parameter int X_RFW_WIDTH = 32,
   parameter int DEPTH       = 4
);
   localparam int RES_W = X_ID_WIDTH + X_RFW_WIDTH + 22;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic                  commit_valid_i;
   logic [X_ID_WIDTH-1:0] commit_id_i;
   logic                  commit_kill_i;

   logic                  fu_valid_i;
   logic                  fu_ready_o;
   logic [RES_W-1:0]      fu_result_i;

   logic                  result_valid_o;
   logic                  result_ready_i;
   logic [RES_W-1:0]      result_o;

   logic [CNT_W-1:0]      count_o;

   modport slave (
      input  commit_valid_i, commit_id_i, commit_kill_i,
      input  fu_valid_i, fu_result_i,
      output fu_ready_o,
      output result_valid_o, result_o,
      input  result_ready_i,
      output count_o
   );

   modport master (
      output commit_valid_i, commit_id_i, commit_kill_i,
      output fu_valid_i, fu_result_i,
      input  fu_ready_o,
      input  result_valid_o, result_o,
      output result_ready_i,
      input  count_o
   );
endinterface
`default_nettype wire

// File: rtl/cv32e40s_xif_result_buffer.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40s_xif_result_buffer
// Description : Coprocessor-side result FIFO. Functional-unit results are
//               queued in arrival order; the head is offered to the core only
//               once its id has been committed, and is silently dropped if
//               its id was killed. A per-id commit table remembers commit or
//               kill decisions that arrive before the result itself.
// Ports       : clk  - clock
//               rst  - asynchronous active-high reset
//               bus  - slave modport carrying the commit channel, the FU
//                      result channel, the core result channel and count_o
//               Result packing (MSB first): id, data, rd[4:0], we[0],
//               ecsdata[5:0], ecswe[2:0], exc, exccode[5:0]
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40s_xif_result_buffer #(
   parameter int X_ID_WIDTH  = 4,
   parameter int X_RFW_WIDTH = 32,
   parameter int DEPTH       = 4
) (
   input wire logic                   clk,
   input wire logic                   rst,
   cv32e40s_xif_result_buffer_if.slave bus
);

   localparam int RES_W = X_ID_WIDTH + X_RFW_WIDTH + 22;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int N_IDS = 2 ** X_ID_WIDTH;

   // Commit table entry encoding
   localparam logic [1:0] c_NONE      = 2'd0;
   localparam logic [1:0] c_COMMITTED = 2'd1;
   localparam logic [1:0] c_KILLED    = 2'd2;

   logic [RES_W-1:0]      r_mem [DEPTH];
   logic [PTR_W-1:0]      r_wptr;
   logic [PTR_W-1:0]      r_rptr;
   logic [CNT_W-1:0]      r_count;
   logic [1:0]            r_table [N_IDS];

   logic [RES_W-1:0]      w_head;
   logic [X_ID_WIDTH-1:0] w_head_id;
   logic [1:0]            w_head_state;
   logic                  w_nonempty;
   logic                  w_present;
   logic                  w_drop;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_fu_ready;

   assign w_head       = r_mem[r_rptr];
   assign w_head_id    = w_head[RES_W-1 -: X_ID_WIDTH];
   assign w_head_state = r_table[w_head_id];
   assign w_nonempty   = (r_count != '0);

   // Head decisions use only registered state, so result_valid_o/result_o
   // cannot change until the head is popped.
   assign w_present  = w_nonempty && (w_head_state == c_COMMITTED);
   assign w_drop     = w_nonempty && (w_head_state == c_KILLED);
   assign w_pop      = (w_present && bus.result_ready_i) || w_drop;
   assign w_fu_ready = (r_count != CNT_W'(DEPTH));
   assign w_push     = bus.fu_valid_i && w_fu_ready;

   assign bus.fu_ready_o     = w_fu_ready;
   assign bus.result_valid_o = w_present;
   assign bus.result_o       = w_head;
   assign bus.count_o        = r_count;

   // FIFO storage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_push) begin
         r_mem[r_wptr] <= bus.fu_result_i;
      end
   end

   // Pointers wrap naturally; full/empty come from the count alone
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

   // Commit table. A decision is recorded only into a free (NONE) entry, so
   // repeated commits/kills are ignored. When the entry is being freed by a
   // pop in the same cycle, the incoming decision belongs to a new
   // instruction reusing the id and therefore takes precedence over the clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_IDS; i++) begin
            r_table[i] <= c_NONE;
         end
      end else begin
         for (int i = 0; i < N_IDS; i++) begin
            if (bus.commit_valid_i && (bus.commit_id_i == X_ID_WIDTH'(i)) &&
                ((r_table[i] == c_NONE) || (w_pop && (w_head_id == X_ID_WIDTH'(i))))) begin
               r_table[i] <= bus.commit_kill_i ? c_KILLED : c_COMMITTED;
            end else if (w_pop && (w_head_id == X_ID_WIDTH'(i))) begin
               r_table[i] <= c_NONE;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cv32e40s_xif_result_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cv32e40s_xif_result_buffer
// Description : Self-checking bench for cv32e40s_xif_result_buffer. A cycle
//               vector table drives commits/pushes/ready and checks valid,
//               count and ready after each edge; a scoreboard queue holds the
//               results expected on the core interface, in order, and is
//               compared at every completed handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cv32e40s_xif_result_buffer;

   localparam int X_ID_WIDTH  = 4;
   localparam int X_RFW_WIDTH = 32;
   localparam int DEPTH       = 4;
   localparam int RES_W       = X_ID_WIDTH + X_RFW_WIDTH + 22;

   logic clk;
   logic rst;

   cv32e40s_xif_result_buffer_if #(
      .X_ID_WIDTH  (X_ID_WIDTH),
      .X_RFW_WIDTH (X_RFW_WIDTH),
      .DEPTH       (DEPTH)
   ) bus ();

   cv32e40s_xif_result_buffer #(
      .X_ID_WIDTH  (X_ID_WIDTH),
      .X_RFW_WIDTH (X_RFW_WIDTH),
      .DEPTH       (DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int n_deliv = 0;

   logic [RES_W-1:0] exp_q [$];

   typedef struct {
      logic        fv;
      logic [3:0]  id;
      logic [31:0] data;
      logic [4:0]  rd;
      logic        dlv;
      logic        cv;
      logic [3:0]  cid;
      logic        ck;
      logic        rr;
      logic        ev;
      logic [2:0]  ecnt;
      logic        erdy;
   } vec_t;

   vec_t vecs [$];

   function automatic logic [RES_W-1:0] mk(input logic [3:0] id, input logic [31:0] data,
                                           input logic [4:0] rd);
      return {id, data, rd, 1'b1, {1'b0, rd}, 3'b101, 1'b0, 6'h2A};
   endfunction

   function automatic vec_t v(input logic fv, input logic [3:0] id, input logic [31:0] data,
                              input logic [4:0] rd, input logic dlv, input logic cv,
                              input logic [3:0] cid, input logic ck, input logic rr,
                              input logic ev, input logic [2:0] ecnt, input logic erdy);
      vec_t r;
      r.fv = fv; r.id = id; r.data = data; r.rd = rd; r.dlv = dlv;
      r.cv = cv; r.cid = cid; r.ck = ck; r.rr = rr;
      r.ev = ev; r.ecnt = ecnt; r.erdy = erdy;
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      bus.fu_valid_i     = 1'b0;
      bus.commit_valid_i = 1'b0;
      bus.commit_kill_i  = 1'b0;
      bus.result_ready_i = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard and stall-stability monitor, sampled mid-cycle
   logic             prev_stall = 1'b0;
   logic [RES_W-1:0] prev_res   = '0;

   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid_held", 64'(bus.result_valid_o), 64'd1);
            chk("stall_result_held", 64'(bus.result_o), 64'(prev_res));
         end
         if (bus.result_valid_o && bus.result_ready_i) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got %h expected no result", bus.result_o);
            end else begin
               chk("delivered_result", 64'(bus.result_o), 64'(exp_q.pop_front()));
            end
            n_deliv++;
         end
         prev_stall = bus.result_valid_o && !bus.result_ready_i;
         prev_res   = bus.result_o;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int sent;
      int base;

      rst = 1'b1;
      idle();
      bus.commit_id_i = '0;
      bus.fu_result_i = '0;

      //            fv id data          rd dlv cv cid ck rr  ev cnt rdy
      // single result, committed in the push cycle, stalled twice
      vecs.push_back(v(1, 3, 32'hDEADBEEF, 5, 1, 1, 3, 0, 0, 1, 1, 1));
      vecs.push_back(v(0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 1, 1, 1));
      vecs.push_back(v(0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 1, 1, 1));
      vecs.push_back(v(0, 0, 32'h0,        0, 0, 0, 0, 0, 1, 0, 0, 1));
      // id 3 reused: table entry must have been freed by the pop
      vecs.push_back(v(1, 3, 32'h11111111, 1, 1, 0, 0, 0, 0, 0, 1, 1));
      vecs.push_back(v(0, 0, 32'h0,        0, 0, 1, 3, 0, 0, 1, 1, 1));
      vecs.push_back(v(0, 0, 32'h0,        0, 0, 0, 0, 0, 1, 0, 0, 1));
      // fill with uncommitted ids 1..4, push while full is refused
      vecs.push_back(v(1, 1, 32'h00000101, 1, 1, 0, 0, 0, 0, 0, 1, 1));
      vecs.push_back(v(1, 2, 32'h00000102, 2, 1, 0, 0, 0, 0, 0, 2, 1));
      vecs.push_back(v(1, 3, 32'h00000103, 3, 1, 0, 0, 0, 0, 0, 3, 1));
      vecs.push_back(v(1, 4, 32'h00000104, 4, 1, 0, 0, 0, 0, 0, 4, 0));
      vecs.push_back(v(1, 9, 32'h00000999, 9, 0, 0, 0, 0, 0, 0, 4, 0));
      vecs.push_back(v(0, 0, 32'h0,        0, 0, 1, 1, 0, 0, 1, 4, 0));
      vecs.push_back(v(0, 0, 32'h0,        0, 0, 0, 0, 0, 1, 0, 3, 1));
      vecs.push_back(v(0, 0, 32'h0,        0, 0, 1, 2, 0, 1, 1, 3, 1));
      vecs.push_back(v(0, 0, 32'h0,        0, 0, 1, 3, 0, 1, 1, 2, 1));
      vecs.push_back(v(0, 0, 32'h0,        0, 0, 1, 4, 0, 1, 1, 1, 1));
      vecs.push_back(v(0, 0, 32'h0,        0, 0, 0, 0, 0, 1, 0, 0, 1));
      // killed head is dropped, following committed id comes through
      vecs.push_back(v(1, 2, 32'h00000022, 2, 0, 0, 0, 0, 0, 0, 1, 1));
      vecs.push_back(v(1, 5, 32'h00000055, 5, 1, 0, 0, 0, 0, 0, 2, 1));
      vecs.push_back(v(0, 0, 32'h0,        0, 0, 1, 2, 1, 0, 0, 2, 1));
      vecs.push_back(v(0, 0, 32'h0,        0, 0, 1, 5, 0, 0, 1, 1, 1));
      vecs.push_back(v(0, 0, 32'h0,        0, 0, 0, 0, 0, 1, 0, 0, 1));
      // commit before push, later kill of the same id ignored
      vecs.push_back(v(0, 0, 32'h0,        0, 0, 1, 7, 0, 0, 0, 0, 1));
      vecs.push_back(v(1, 7, 32'h00000077, 7, 1, 0, 0, 0, 0, 1, 1, 1));
      vecs.push_back(v(0, 0, 32'h0,        0, 0, 1, 7, 1, 0, 1, 1, 1));
      vecs.push_back(v(0, 0, 32'h0,        0, 0, 0, 0, 0, 1, 0, 0, 1));
      // commit coinciding with pop-clear of the same id is kept
      vecs.push_back(v(1, 6, 32'h00000066, 6, 1, 1, 6, 0, 0, 1, 1, 1));
      vecs.push_back(v(0, 0, 32'h0,        0, 0, 1, 6, 0, 1, 0, 0, 1));
      vecs.push_back(v(1, 6, 32'h00000067, 6, 1, 0, 0, 0, 0, 1, 1, 1));
      vecs.push_back(v(0, 0, 32'h0,        0, 0, 0, 0, 0, 1, 0, 0, 1));

      step();
      step();
      rst = 1'b0;
      step();
      chk("reset_valid", 64'(bus.result_valid_o), 64'd0);
      chk("reset_count", 64'(bus.count_o), 64'd0);
      chk("reset_ready", 64'(bus.fu_ready_o), 64'd1);
      chk("reset_result", 64'(bus.result_o), 64'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         bus.fu_valid_i     = vecs[i].fv;
         bus.fu_result_i    = mk(vecs[i].id, vecs[i].data, vecs[i].rd);
         bus.commit_valid_i = vecs[i].cv;
         bus.commit_id_i    = vecs[i].cid;
         bus.commit_kill_i  = vecs[i].ck;
         bus.result_ready_i = vecs[i].rr;
         if (vecs[i].fv && vecs[i].dlv) begin
            exp_q.push_back(mk(vecs[i].id, vecs[i].data, vecs[i].rd));
         end
         step();
         chk($sformatf("vec%0d_valid", i), 64'(bus.result_valid_o), 64'(vecs[i].ev));
         chk($sformatf("vec%0d_count", i), 64'(bus.count_o), 64'(vecs[i].ecnt));
         chk($sformatf("vec%0d_ready", i), 64'(bus.fu_ready_o), 64'(vecs[i].erdy));
      end
      idle();
      chk("vectors_delivered", 64'(n_deliv), 64'd10);

      // Stream of 10 committed results with toggling back-pressure
      sent = 0;
      base = n_deliv;
      for (int cyc = 0; cyc < 200 && (n_deliv - base) < 10; cyc++) begin
         bus.result_ready_i = (cyc % 2 == 0);
         if (sent < 10 && bus.fu_ready_o) begin
            bus.fu_valid_i     = 1'b1;
            bus.fu_result_i    = mk(4'(sent), 32'hA5000000 + 32'(sent * 7), 5'(sent + 10));
            bus.commit_valid_i = 1'b1;
            bus.commit_id_i    = 4'(sent);
            bus.commit_kill_i  = 1'b0;
            exp_q.push_back(mk(4'(sent), 32'hA5000000 + 32'(sent * 7), 5'(sent + 10)));
            sent++;
         end else begin
            bus.fu_valid_i     = 1'b0;
            bus.commit_valid_i = 1'b0;
         end
         step();
      end
      idle();
      chk("stream_delivered", 64'(n_deliv - base), 64'd10);
      chk("stream_empty", 64'(bus.count_o), 64'd0);

      // Asynchronous reset with three entries queued and one valid
      bus.fu_valid_i = 1'b1; bus.fu_result_i = mk(4'd10, 32'h0A0A0A0A, 5'd10);
      bus.commit_valid_i = 1'b1; bus.commit_id_i = 4'd10;
      step();
      bus.fu_result_i = mk(4'd11, 32'h0B0B0B0B, 5'd11); bus.commit_id_i = 4'd11;
      step();
      bus.fu_result_i = mk(4'd12, 32'h0C0C0C0C, 5'd12); bus.commit_valid_i = 1'b0;
      step();
      idle();
      chk("prereset_count", 64'(bus.count_o), 64'd3);
      chk("prereset_valid", 64'(bus.result_valid_o), 64'd1);
      #1;
      rst = 1'b1;
      #1;
      chk("async_reset_valid", 64'(bus.result_valid_o), 64'd0);
      chk("async_reset_count", 64'(bus.count_o), 64'd0);
      chk("async_reset_ready", 64'(bus.fu_ready_o), 64'd1);
      step();
      rst = 1'b0;

      // id 11 was committed before reset: it must now wait for a new commit
      bus.fu_valid_i  = 1'b1;
      bus.fu_result_i = mk(4'd11, 32'h1B1B1B1B, 5'd3);
      exp_q.push_back(mk(4'd11, 32'h1B1B1B1B, 5'd3));
      step();
      idle();
      chk("postreset_wait_count", 64'(bus.count_o), 64'd1);
      chk("postreset_wait_valid", 64'(bus.result_valid_o), 64'd0);
      step();
      chk("postreset_wait2_valid", 64'(bus.result_valid_o), 64'd0);
      bus.commit_valid_i = 1'b1; bus.commit_id_i = 4'd11;
      step();
      bus.commit_valid_i = 1'b0;
      chk("postreset_commit_valid", 64'(bus.result_valid_o), 64'd1);
      bus.result_ready_i = 1'b1;
      step();
      idle();
      chk("postreset_pop_count", 64'(bus.count_o), 64'd0);
      chk("postreset_pop_valid", 64'(bus.result_valid_o), 64'd0);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      chk("total_delivered", 64'(n_deliv), 64'd21);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cv32e40s_xif_result_buffer.md
# cv32e40s_xif_result_buffer

Coprocessor-side buffer between the coprocessor execution units and the core's eXtension result interface. Results from the functional unit enter a FIFO in arrival order. The head result goes to the core only after the commit interface has committed its id; if the commit interface kills the id, the head result is silently dropped. This keeps uncommitted or killed offloaded instructions from ever writing back, and decouples functional-unit completion from the core's result_ready back-pressure.

## Interface
Parameters:
- X_ID_WIDTH, 4: width of instruction id; commit table has 2**X_ID_WIDTH entries.
- X_RFW_WIDTH, 32: result data width; must be 32 (X_RFW_WIDTH/XLEN = 1 write enable).
- DEPTH, 4: FIFO entries; power of two, >= 2.
- RES_W, derived: X_ID_WIDTH+X_RFW_WIDTH+22.
  - Packed result layout, MSB first: id, data, rd[4:0], we[0], ecsdata[5:0], ecswe[2:0], exc, exccode[5:0].

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock, reset asynchronous and active-high.
- commit_valid_i  in  1  commit transaction valid.
- commit_id_i  in  X_ID_WIDTH  id being committed or killed.
- commit_kill_i  in  1  1 = kill id, 0 = commit id.
- fu_valid_i  in  1  functional-unit result valid.
- fu_ready_o  out  1  buffer can accept a result.
- fu_result_i  in  RES_W  packed result.
- result_valid_o  out  1  core result interface valid.
- result_ready_i  in  1  core accepts result.
- result_o  out  RES_W  head result, same packing.
- count_o  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- FIFO: write pointer, read pointer and count registers. Push when fu_valid_i && fu_ready_o. fu_ready_o = (count != DEPTH), combinational from count; no same-cycle pop-to-push bypass.
- Commit table: per id, a 2-bit state register with values NONE, COMMITTED, KILLED.
  - commit_valid_i writes COMMITTED or KILLED (per commit_kill_i) only if the entry is NONE. A repeat commit or kill for a non-NONE id is ignored.
- Head evaluation, when count > 0, uses the registered table state of head.id:
  - COMMITTED: result_valid_o = 1, result_o = head. Pop on result_ready_i; the table entry is cleared to NONE on pop.
  - KILLED: result_valid_o = 0; head dropped (pop) in that cycle; table entry cleared to NONE.
  - NONE: result_valid_o = 0; wait. Head-of-line blocking is intended.
- When count = 0: result_valid_o = 0; result_o = the entry at the read pointer (don't care).
- Stability: once result_valid_o = 1, result_o and result_valid_o hold until the handshake. The head's state cannot leave COMMITTED except by pop.
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged; pointers both advance modulo DEPTH.
  - Commit write and pop-clear to the same id in the same cycle: the commit write wins (the id is being reused by a new instruction).
  - Commit for an id not yet in the FIFO: held in the table until the result arrives.
- Pointer wrap: pointers are $clog2(DEPTH) bits, naturally wrapping; full/empty decided from count only.

## Timing
- Reset values:
  - result_valid_o = 0, count_o = 0, fu_ready_o = 1.
  - result_o = 0 (FIFO storage reset to 0).
  - All table entries NONE; pointers 0.
- Reset asserted mid-operation discards all entries and table state immediately (asynchronous). No result handshake completes in a cycle where rst is high.
- Latency, push at cycle N:
  - If id was already COMMITTED before N: result_valid_o = 1 at N+1, if it is at the head.
  - If commit arrives at cycle M >= N: result_valid_o = 1 at M+1, if at the head.
- Killed head drop takes exactly 1 cycle per entry.
- Throughput: 1 result/cycle with result_ready_i held high and all heads committed.
- count_o updates the cycle after push or pop.

## Test plan
- Reset, then push id 3 (data 0xDEADBEEF, rd 5, we 1). Commit id 3 (kill 0) in the same cycle -> result_valid_o = 1 exactly one cycle later with data 0xDEADBEEF, rd 5; held until result_ready_i = 1, then count_o = 0 and table[3] = NONE.
- Push ids 1, 2, 3, 4 with no commits -> fu_ready_o = 0 after the 4th push, count_o = 4, result_valid_o = 0. Commit id 1 -> valid next cycle; pop -> fu_ready_o = 1.
- Push id 2 then id 5. Kill id 2, commit id 5 -> id 2 never appears on result_valid_o. Id 5 presented 2 cycles after commits (1 drop cycle + present).
- Commit id 7 before any push, then push id 7 -> result_valid_o = 1 the cycle after the push. A second commit with kill = 1 for id 7 before the pop is ignored; the result is still delivered.
- With result_ready_i toggling 1/0, stream 10 committed results (ids 0..9, wrapping pointers twice) -> in-order delivery, no loss, result_o stable while stalled.
- Assert rst with count_o = 3 and result_valid_o = 1 -> result_valid_o = 0 and count_o = 0 immediately. A post-reset push of an id that was committed before reset waits for a fresh commit.
